// File: rtl/lisnoc_router_vc_link_sched_pkg.sv
// Shared definitions for the router output-link scheduler.
// Flit type codes live in the two MSBs of every flit. This package holds them,
// together with the flit-width and index-width arithmetic used by the link scheduler.
package lisnoc_router_vc_link_sched_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_TYPE_PAYLOAD = 2'b00,
    FLIT_TYPE_HEADER  = 2'b01,
    FLIT_TYPE_LAST    = 2'b10,
    FLIT_TYPE_SINGLE  = 2'b11
  } flit_type_e;

  // Full flit width: the type bits sit above the payload.
  function automatic int flit_width_of(input int data_width, input int type_width);
    return data_width + type_width;
  endfunction

  // Width of a VC index. It never drops to zero bits, so a single-VC build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lisnoc_vc_credit_counter.sv
// Per-VC credit counter that tracks free slots in the downstream input buffer.
// It starts at the full buffer depth, counts down on each grant and counts up on each returned credit.
// overflow_o pulses when a credit is returned while the counter is already full.
module lisnoc_vc_credit_counter #(
  parameter int credits      = 4,
  parameter int credit_width = $clog2(credits + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic overflow_o
);

  localparam logic [credit_width-1:0] CNT_MAX = credit_width'(credits);
  localparam logic [credit_width-1:0] CNT_ONE = credit_width'(1);

  logic [credit_width-1:0] cnt_q, cnt_d;

  // Next count: a grant and a credit in the same cycle cancel out.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -> no latch inferred.
    cnt_d      = cnt_q;
    overflow_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) overflow_o = 1'b1;
        else                  cnt_d      = cnt_q + CNT_ONE;
      end
      // The scheduler never grants a VC whose counter is zero, so this decrement cannot underflow.
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register; reset restores the full downstream buffer depth.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) cnt_q <= CNT_MAX;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lisnoc_router_vc_link_sched.sv
// Output-link scheduler: shares one router output link among the VCs of that port.
// Credit-based flow control toward the downstream buffer; per-flit round-robin among eligible VCs.
// The link output stage is registered, so a flit granted in cycle n is on the link in cycle n+1.
// Optional macro LISNOC_VC_PKT_LOCK_EN: a granted HEADER flit locks the link to its VC until that
// VC's LAST flit is granted. When the macro is undefined, VCs interleave flit by flit.
module lisnoc_router_vc_link_sched
  import lisnoc_router_vc_link_sched_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 3,
  parameter int credits         = 4,
  parameter int credit_width    = $clog2(credits + 1),
  localparam int flit_width     = flit_width_of(flit_data_width, flit_type_width)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [flit_width*vchannels-1:0] flit_i,
  input  logic [vchannels-1:0]            valid_i,
  output logic [vchannels-1:0]            ready_o,
  input  logic [vchannels-1:0]            credit_i,
  output logic [flit_width-1:0]           link_flit_o,
  output logic                            link_valid_o,
  output logic [vchannels-1:0]            link_vc_o,
  output logic                            err_o
);

  localparam int IDX_W = idx_width(vchannels);

  logic [flit_width-1:0] flit_arr [vchannels];
  logic [vchannels-1:0]  cnt_zero, cnt_overflow, lock_mask, eligible, grant;
  logic [IDX_W-1:0]      grant_idx, rr_ptr_q, rr_ptr_d;
  logic                  any_grant;
  logic [flit_width-1:0] granted_flit;

  logic [flit_width-1:0] link_flit_q, link_flit_d;
  logic                  link_valid_q, link_valid_d;
  logic [vchannels-1:0]  link_vc_q, link_vc_d;
  logic                  err_q, err_d;

  // One credit counter per VC, plus an unpacked view of each VC's flit.
  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    assign flit_arr[v] = flit_i[flit_width*(v+1)-1 : flit_width*v];

    lisnoc_vc_credit_counter #(
      .credits      (credits),
      .credit_width (credit_width)
    ) u_credit_counter (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (credit_i[v]),
      .dec_i      (grant[v]),
      .zero_o     (cnt_zero[v]),
      .overflow_o (cnt_overflow[v])
    );
  end

`ifdef LISNOC_VC_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_vc_q, lock_vc_d;
  flit_type_e       granted_type;

  // Lock tracking: a HEADER flit opens a packet lock and the matching LAST flit releases it.
  always_comb begin
    lock_d       = lock_q;
    lock_vc_d    = lock_vc_q;
    granted_type = flit_type_e'(granted_flit[flit_width-1 -: FLIT_TYPE_W]);
    lock_mask    = lock_q ? (vchannels'(1) << lock_vc_q) : '1;
    if (any_grant) begin
      if (lock_q) begin
        if (granted_type == FLIT_TYPE_LAST) lock_d = 1'b0;
      end else if (granted_type == FLIT_TYPE_HEADER) begin
        lock_d    = 1'b1;
        lock_vc_d = grant_idx;
      end
    end
  end

  // Lock register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end
`else
  assign lock_mask = '1;
`endif

  // No grant during reset, so no flit is consumed while the state is being discarded.
  assign eligible = valid_i & ~cnt_zero & lock_mask & {vchannels{~rst}};

  // Round-robin pick: the lowest eligible index above the pointer wins; otherwise wrap to the lowest index at or below it.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr_q;
    any_grant = 1'b0;
    for (int v = vchannels - 1; v >= 0; v--) begin
      if (eligible[v] && (v <= int'(rr_ptr_q))) begin
        grant_idx = IDX_W'(v);
        any_grant = 1'b1;
      end
    end
    for (int v = vchannels - 1; v >= 0; v--) begin
      if (eligible[v] && (v > int'(rr_ptr_q))) begin
        grant_idx = IDX_W'(v);
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

  assign ready_o      = grant;
  assign granted_flit = flit_arr[grant_idx];

  // Next pointer and output stage: the pointer moves only on a grant, and link_valid/link_vc drop in idle cycles.
  always_comb begin
    rr_ptr_d     = any_grant ? grant_idx : rr_ptr_q;
    link_valid_d = any_grant;
    link_vc_d    = grant;
    link_flit_d  = any_grant ? granted_flit : link_flit_q;
    err_d        = err_q | (|cnt_overflow);
  end

  // Pointer, output register and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= IDX_W'(vchannels - 1);
      link_flit_q  <= '0;
      link_valid_q <= 1'b0;
      link_vc_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      link_flit_q  <= link_flit_d;
      link_valid_q <= link_valid_d;
      link_vc_q    <= link_vc_d;
      err_q        <= err_d;
    end
  end

  assign link_flit_o  = link_flit_q;
  assign link_valid_o = link_valid_q;
  assign link_vc_o    = link_vc_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lisnoc_router_vc_link_sched.sv
// Self-checking bench for lisnoc_router_vc_link_sched: directed scenarios, then a randomized run.
// Each cycle is compared against a queue-free behavioural model: per-VC credit counts, a modular
// round-robin search and, when LISNOC_VC_PKT_LOCK_EN is defined, the packet-lock rule.
module tb_lisnoc_router_vc_link_sched;
  import lisnoc_router_vc_link_sched_pkg::*;

  localparam int DW = 32, TW = 2, FW = DW + TW, V = 3, CR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [FW*V-1:0]   flit_i;
  logic [V-1:0]      valid_i, credit_i, ready_o, link_vc_o;
  logic [FW-1:0]     link_flit_o;
  logic              link_valid_o, err_o;

  always #5 clk = ~clk;

  lisnoc_router_vc_link_sched #(
    .flit_data_width (DW),
    .flit_type_width (TW),
    .vchannels       (V),
    .credits         (CR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_i       (flit_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .credit_i     (credit_i),
    .link_flit_o  (link_flit_o),
    .link_valid_o (link_valid_o),
    .link_vc_o    (link_vc_o),
    .err_o        (err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int            m_cnt [V];
  int            m_ptr;
  bit            m_err, m_lock;
  int            m_lock_vc;
  logic [FW-1:0] m_flit;
  logic          m_lv;
  logic [V-1:0]  m_lvc;
  logic [V-1:0]  last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < V; v++) m_cnt[v] = CR;
    m_ptr = V - 1; m_err = 0; m_lock = 0; m_lock_vc = 0;
    m_flit = '0; m_lv = 0; m_lvc = '0;
  endfunction

  // Returns the VC the rules say should be granted, or -1 if none.
  function automatic int model_pick(input logic [V-1:0] valid);
    for (int k = 1; k <= V; k++) begin
      int idx;
      idx = (m_ptr + k) % V;
      if (valid[idx] && m_cnt[idx] > 0 && (!m_lock || idx == m_lock_vc)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  function automatic logic [FW*V-1:0] rand_flits(input bit any_type);
    logic [FW*V-1:0] r;
    for (int v = 0; v < V; v++)
      r[v*FW +: FW] = mk(any_type ? 2'($urandom_range(0, 3)) : 2'b00, $urandom);
    return r;
  endfunction

  // One clock cycle: drive after the falling edge, check ready, then check registered outputs after the rising edge.
  task automatic cycle(input logic r, input logic [V-1:0] v, input logic [V-1:0] c,
                       input logic [FW*V-1:0] f, output int g);
    logic [V-1:0] exp_ready;
    logic [1:0]   typ;
    @(negedge clk);
    rst = r; valid_i = v; credit_i = c; flit_i = f;
    #1;
    g = r ? -1 : model_pick(v);
    exp_ready = (g < 0) ? '0 : (V'(1) << g);
    last_ready = ready_o;
    check("ready_o", ready_o, exp_ready);
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      for (int i = 0; i < V; i++) begin
        if (c[i] && g != i) begin
          if (m_cnt[i] == CR) m_err = 1;
          else m_cnt[i]++;
        end else if (!c[i] && g == i) m_cnt[i]--;
      end
      if (g >= 0) begin
        m_ptr = g; m_flit = f[g*FW +: FW]; m_lv = 1; m_lvc = V'(1) << g;
`ifdef LISNOC_VC_PKT_LOCK_EN
        typ = m_flit[FW-1 -: 2];
        if (m_lock) begin
          if (typ == FLIT_TYPE_LAST) m_lock = 0;
        end else if (typ == FLIT_TYPE_HEADER) begin
          m_lock = 1; m_lock_vc = g;
        end
`else
        typ = 2'b00;
`endif
      end else begin
        m_lv = 0; m_lvc = '0;
      end
    end
    check("link_valid_o", link_valid_o, m_lv);
    check("link_vc_o", link_vc_o, m_lvc);
    check("link_flit_o", link_flit_o, m_flit);
    check("err_o", err_o, m_err);
  endtask

  int g, n;
  logic [V-1:0] rv, rc;

  initial begin
    rst = 1'b1; valid_i = '0; credit_i = '0; flit_i = '0; last_ready = '0;
    model_reset();

    // Reset state.
    cycle(1, '0, '0, '0, g);
    cycle(1, '0, '0, '0, g);
    cycle(0, '0, '0, '0, g);
    check("reset_ready", last_ready, '0);

    // 1: VC0 alone with no credit returns gets exactly four grants, then stalls.
    n = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(0, 3'b001, '0, rand_flits(0), g);
      if (last_ready == 3'b001) n++;
    end
    check("t1_grant_count", 64'(n), 64'd4);

    // 2: all VCs valid -> 001, 010, 100, 001, ...
    cycle(1, '0, '0, '0, g);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 3'b111, '0, rand_flits(0), g);
      check("t2_rr_order", last_ready, 3'b001 << (i % 3));
    end

    // 3: VC1 drains its credits; one returned credit makes it eligible only in the following cycle.
    cycle(1, '0, '0, '0, g);
    for (int i = 0; i < 5; i++) cycle(0, 3'b010, '0, rand_flits(0), g);
    check("t3_blocked", last_ready, 3'b000);
    cycle(0, 3'b010, 3'b010, rand_flits(0), g);
    check("t3_credit_same_cycle", last_ready, 3'b000);
    cycle(0, 3'b010, '0, rand_flits(0), g);
    check("t3_credit_next_cycle", last_ready, 3'b010);
    cycle(0, 3'b010, 3'b010, rand_flits(0), g);  // credit back, count 0 -> 1
    cycle(0, 3'b010, 3'b010, rand_flits(0), g);  // grant + credit, count stays 1
    check("t3_grant_and_credit", last_ready, 3'b010);
    cycle(0, 3'b010, '0, rand_flits(0), g);
    check("t3_last_credit", last_ready, 3'b010);
    cycle(0, 3'b010, '0, rand_flits(0), g);
    check("t3_drained", last_ready, 3'b000);

    // 4: a credit returned to a full counter sets a sticky error that only reset clears.
    cycle(1, '0, '0, '0, g);
    cycle(0, '0, 3'b001, '0, g);
    check("t4_err_set", err_o, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 3'b001, '0, rand_flits(0), g);
    check("t4_err_held", err_o, 1'b1);
    cycle(1, '0, '0, '0, g);
    check("t4_err_cleared", err_o, 1'b0);

    // 5: packet lock holds the link for VC0 while it waits, or interleaving when the lock is disabled.
    cycle(0, 3'b011, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(FLIT_TYPE_HEADER, 32'h10)}, g);
    check("t5_header", last_ready, 3'b001);
    cycle(0, 3'b010, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(0, 32'h0)}, g);
`ifdef LISNOC_VC_PKT_LOCK_EN
    check("t5_locked_1", last_ready, 3'b000);
    cycle(0, 3'b010, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(0, 32'h0)}, g);
    check("t5_locked_2", last_ready, 3'b000);
    cycle(0, 3'b011, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(FLIT_TYPE_PAYLOAD, 32'h12)}, g);
    check("t5_payload", last_ready, 3'b001);
    cycle(0, 3'b011, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(FLIT_TYPE_LAST, 32'h13)}, g);
    check("t5_last", last_ready, 3'b001);
    cycle(0, 3'b011, '0, {mk(0, 32'h2), mk(FLIT_TYPE_SINGLE, 32'h11), mk(0, 32'h14)}, g);
    check("t5_unlocked", last_ready, 3'b010);
`else
    check("t5_interleave", last_ready, 3'b010);
`endif

    // 6: reset in the middle of a VC2 packet restores every counter, the pointer and the outputs.
    cycle(1, '0, '0, '0, g);
    cycle(0, 3'b100, '0, {mk(FLIT_TYPE_HEADER, 32'h20), 68'h0}, g);
    cycle(0, 3'b100, '0, {mk(FLIT_TYPE_PAYLOAD, 32'h21), 68'h0}, g);
    cycle(0, 3'b100, '0, {mk(FLIT_TYPE_PAYLOAD, 32'h22), 68'h0}, g);
    cycle(1, 3'b111, '0, rand_flits(0), g);
    check("t6_rst_ready", last_ready, 3'b000);
    check("t6_rst_link_valid", link_valid_o, 1'b0);
    cycle(0, 3'b111, '0, rand_flits(0), g);
    check("t6_vc0_first", last_ready, 3'b001);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 3'b100, '0, rand_flits(0), g);
      if (last_ready == 3'b100) n++;
    end
    check("t6_vc2_full_credits", 64'(n), 64'd4);

    // Randomized traffic: mostly legal credit returns, rare overflows and rare resets.
    cycle(1, '0, '0, '0, g);
    for (int i = 0; i < 600; i++) begin
      rv = V'($urandom);
      for (int v = 0; v < V; v++)
        rc[v] = ((m_cnt[v] < CR) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 96) == 0);
      cycle(($urandom_range(0, 149) == 0), rv, rc, rand_flits(1), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
